nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
Sequencing controller that performs WIDTH = 4*NIBBLES-bit add/subtract by time-multiplexing a single 4-bit ripple adder, one nibble per clock, least significant nibble first. Operands arrive on a valid/ready input handshake. The result leaves on a valid/ready output handshake with carry-out and signed overflow. The block is the multi-precision front end for the nibble adder datapath. Area is traded for latency.

Parameters:
- NIBBLES, 4, number of 4-bit limbs per operand (WIDTH = 4*NIBBLES); legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operation.
- in_a  input  4*NIBBLES  operand A.
- in_b  input  4*NIBBLES  operand B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- in_sub  input  1  1 = compute A-B (B complemented, carry-in forced 1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_sum  output  4*NIBBLES  result.
- out_cout  output  1  final carry (for subtract: 1 = no borrow).
- out_ovf  output  1  two's-complement overflow.

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, nibble index=0, carry reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch:
  - A
  - B_eff = in_sub ? ~in_b : in_b
  - carry = in_sub ? 1 : in_cin
  - idx = 0
  - then go to RUN.
- RUN: in_ready=0. Each cycle the adder sees A[idx], B_eff[idx], carry. Its sum nibble is registered into sum[idx] and its carry-out into the carry reg; idx increments.
- Leaving RUN: when idx==NIBBLES-1, go to DONE and assert out_valid on the same edge. Compute in parallel:
  - out_cout = final carry
  - out_ovf = (A[MSB]==B_eff[MSB]) && (sum[MSB]!=A[MSB])
- Latency: input handshake at edge T, out_valid high after edge T+NIBBLES. Exactly NIBBLES adder cycles.
- DONE: out_valid=1; out_sum/out_cout/out_ovf held stable until out_valid&out_ready, then IDLE (out_valid=0).
- Throughput: one operation per NIBBLES+2 cycles with out_ready tied high. No overlap of input accept with DONE.
- Hold stability: out_* must not change while out_valid=1 and out_ready=0. in_a/in_b changes after the accept edge have no effect.
- idx range: 0..NIBBLES-1, never wraps past NIBBLES-1. Width is $clog2(NIBBLES) with a minimum of 1 bit.
- Reset mid-RUN or mid-DONE: next cycle is IDLE with reset values; the in-flight result is discarded and never presented.
- in_valid while not in IDLE: ignored (in_ready=0); the requester must hold it.

Decomposition:
- Shared package constant: NIBBLE_W=4.
- Shared package state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Shared package helper: ovf function (a_msb, b_msb, s_msb).
- One sub-module: the team's existing four_bit_adder, instantiated once as the shared datapath.
- Controller holds the FSM, operand/sum shift or indexed registers, and the carry reg.

Test Plan (NIBBLES=4):
- Add: A=0x1234, B=0x0FFF, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x2233, cout=0, ovf=0.
- Carry wrap: A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. With cin=1, A=0xFFFF, B=0x0000 -> sum=0x0000, cout=1.
- Signed overflow: A=0x7FFF, B=0x0001 add -> sum=0x8000, ovf=1, cout=0.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Also A=0x8000 - B=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0 throughout. Pulse in_valid with new operands during RUN/DONE -> ignored.
- Reset mid-op: assert rst for 1 cycle at second RUN cycle -> out_valid never rises for that op; in_ready=1 next cycle. A following 0x1111+0x2222 yields 0x3333.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// limb width, FSM encoding and the signed-overflow helper.
package nibble_serial_add_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow from the sign bits of both addends and the sum.
    function automatic logic ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Four-bit ripple-carry adder; the single shared datapath element of the
// nibble-serial controller.
module four_bit_adder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-precision add/subtract that walks a single 4-bit adder across the
// operands, least significant nibble first, with valid/ready on both sides.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                        in_cin,
    input  logic                        in_sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_cout,
    output logic                        out_ovf
);

    localparam int unsigned WIDTH = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                    state;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-NIBBLE_W-1:0] sum_sh;
    logic                      carry;
    logic [IDX_W-1:0]          idx;

    logic [NIBBLE_W-1:0]       nib_sum;
    logic                      nib_cout;
    logic [WIDTH-1:0]          sum_next;

    four_bit_adder u_adder (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Operands shift down so nibble idx is always in the low slot; the sum
    // fills from the top so it is fully aligned after the last nibble.
    assign sum_next = {nib_sum, sum_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= in_a;
                        b_sh     <= in_sub ? ~in_b : in_b;
                        carry    <= in_sub ? 1'b1 : in_cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> NIBBLE_W;
                    b_sh   <= b_sh >> NIBBLE_W;
                    sum_sh <= sum_next[WIDTH-1:NIBBLE_W];
                    carry  <= nib_cout;
                    if (idx == LAST_IDX) begin
                        out_sum   <= sum_next;
                        out_cout  <= nib_cout;
                        out_ovf   <= ovf(a_sh[NIBBLE_W-1], b_sh[NIBBLE_W-1], nib_sum[NIBBLE_W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
